// File: rtl/time_set_ctrl_if.sv
// Button and display/counter-enable bundle between the time-setting sequencer and its surroundings.
interface time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       up_hh;
    logic       dn_hh;
    logic       up_mm;
    logic       dn_mm;
    logic       up_ss;
    logic       dn_ss;
    logic       set_mode;
    logic [1:0] field_sel;
    logic       blink;

    modport master (
        output btn_mode, btn_left, btn_right, btn_up, btn_down,
        input  up_hh, dn_hh, up_mm, dn_mm, up_ss, dn_ss,
        input  set_mode, field_sel, blink
    );

    modport slave (
        input  btn_mode, btn_left, btn_right, btn_up, btn_down,
        output up_hh, dn_hh, up_mm, dn_mm, up_ss, dn_ss,
        output set_mode, field_sel, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: field-select FSM, up/down pulse routing with auto-repeat and idle timeout.
// Field blink is built only when TIME_SET_CTRL_BLINK_EN is defined; otherwise blink is tied to 1.
module time_set_ctrl #(
    parameter int HOLD_CYC    = 50_000_000,
    parameter int REPEAT_CYC  = 10_000_000,
    parameter int TIMEOUT_CYC = 1_000_000_000,
    parameter int BLINK_HALF  = 25_000_000
) (
    input  logic           clk,
    input  logic           reset,
    time_set_ctrl_if.slave bus
);
    localparam int REP_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int RC_W    = $clog2(REP_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [RC_W-1:0] HOLD_LAST = RC_W'(HOLD_CYC - 1);
    localparam logic [RC_W-1:0] REP_LAST  = RC_W'(REPEAT_CYC - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    if (HOLD_CYC < 1 || REPEAT_CYC < 2 || TIMEOUT_CYC < 1 || BLINK_HALF < 1) begin : g_param_check
        $error("time_set_ctrl: illegal timing parameters");
    end

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } state_t;

    state_t          state;
    logic            set_mode;
    logic            prev_mode, prev_left, prev_right, prev_up, prev_down;
    logic            up_hh, dn_hh, up_mm, dn_mm, up_ss, dn_ss;
    logic            rep_active, rep_dn, rep_hold;
    logic [RC_W-1:0] rep_cnt;
    logic [TO_W-1:0] to_cnt;

    logic rise_mode, rise_left, rise_right, rise_up, rise_down, any_rise;
    logic in_set, timeout, step, both_keys, key_held;
    logic fire_up, fire_dn, fire;

    // Priority chain: mode/timeout, then a single arrow, then up/down (first press or repeat tick).
    always_comb begin
        rise_mode  = bus.btn_mode  & ~prev_mode;
        rise_left  = bus.btn_left  & ~prev_left;
        rise_right = bus.btn_right & ~prev_right;
        rise_up    = bus.btn_up    & ~prev_up;
        rise_down  = bus.btn_down  & ~prev_down;
        any_rise   = rise_mode | rise_left | rise_right | rise_up | rise_down;
        in_set     = (state != RUN);
        timeout    = in_set && (to_cnt == TO_LAST);
        step       = in_set && !rise_mode && !timeout && (rise_left ^ rise_right);
        both_keys  = bus.btn_up & bus.btn_down;
        key_held   = rep_dn ? bus.btn_down : bus.btn_up;
        fire_up    = 1'b0;
        fire_dn    = 1'b0;
        if (in_set && !rise_mode && !timeout && !step && !both_keys) begin
            if (rise_up || rise_down) begin
                fire_up = rise_up;
                fire_dn = rise_down;
            end else if (rep_active && key_held &&
                         rep_cnt == (rep_hold ? HOLD_LAST : REP_LAST)) begin
                fire_up = ~rep_dn;
                fire_dn = rep_dn;
            end
        end
        fire = fire_up | fire_dn;
    end

    // rep_hold marks the long first interval; afterwards the short repeat interval applies.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            set_mode   <= 1'b0;
            prev_mode  <= 1'b1;
            prev_left  <= 1'b1;
            prev_right <= 1'b1;
            prev_up    <= 1'b1;
            prev_down  <= 1'b1;
            up_hh      <= 1'b0;
            dn_hh      <= 1'b0;
            up_mm      <= 1'b0;
            dn_mm      <= 1'b0;
            up_ss      <= 1'b0;
            dn_ss      <= 1'b0;
            rep_active <= 1'b0;
            rep_dn     <= 1'b0;
            rep_hold   <= 1'b0;
            rep_cnt    <= '0;
            to_cnt     <= '0;
        end else begin
            prev_mode  <= bus.btn_mode;
            prev_left  <= bus.btn_left;
            prev_right <= bus.btn_right;
            prev_up    <= bus.btn_up;
            prev_down  <= bus.btn_down;
            up_hh      <= fire_up && (state == SET_HH);
            dn_hh      <= fire_dn && (state == SET_HH);
            up_mm      <= fire_up && (state == SET_MM);
            dn_mm      <= fire_dn && (state == SET_MM);
            up_ss      <= fire_up && (state == SET_SS);
            dn_ss      <= fire_dn && (state == SET_SS);
            if (!in_set) begin
                to_cnt     <= '0;
                rep_active <= 1'b0;
                if (rise_mode) begin
                    state    <= SET_HH;
                    set_mode <= 1'b1;
                end
            end else if (rise_mode || timeout) begin
                state      <= RUN;
                set_mode   <= 1'b0;
                to_cnt     <= '0;
                rep_active <= 1'b0;
            end else begin
                to_cnt <= (any_rise || fire) ? '0 : to_cnt + 1'b1;
                if (step) begin
                    rep_active <= 1'b0;
                    case (state)
                        SET_HH:  state <= rise_right ? SET_MM : SET_SS;
                        SET_MM:  state <= rise_right ? SET_SS : SET_HH;
                        default: state <= rise_right ? SET_HH : SET_MM;
                    endcase
                end else if (both_keys) begin
                    rep_active <= 1'b0;
                end else if (rise_up || rise_down) begin
                    rep_active <= 1'b1;
                    rep_dn     <= rise_down;
                    rep_hold   <= 1'b1;
                    rep_cnt    <= '0;
                end else if (rep_active && key_held) begin
                    if (fire) begin
                        rep_cnt  <= '0;
                        rep_hold <= 1'b0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end else begin
                    rep_active <= 1'b0;
                end
            end
        end
    end

`ifdef TIME_SET_CTRL_BLINK_EN
    localparam int BL_W = $clog2(BLINK_HALF + 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    logic            blink;
    logic [BL_W-1:0] blink_cnt;

    // Phase restarts showing the field whenever the user touches it, so edits stay visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (!in_set || rise_mode || timeout || step || fire) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt == BL_LAST) begin
            blink     <= ~blink;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign bus.blink = blink;
`else
    assign bus.blink = 1'b1;
`endif

    assign bus.up_hh     = up_hh;
    assign bus.dn_hh     = dn_hh;
    assign bus.up_mm     = up_mm;
    assign bus.dn_mm     = dn_mm;
    assign bus.up_ss     = up_ss;
    assign bus.dn_ss     = dn_ss;
    assign bus.set_mode  = set_mode;
    assign bus.field_sel = state;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl with short timing parameters.
module tb_time_set_ctrl;
    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .HOLD_CYC   (8),
        .REPEAT_CYC (3),
        .TIMEOUT_CYC(40),
        .BLINK_HALF (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order {up_hh, dn_hh, up_mm, dn_mm, up_ss, dn_ss}
    localparam logic [31:0] P_NONE  = 32'h00;
    localparam logic [31:0] P_UP_HH = 32'h20;
    localparam logic [31:0] P_UP_MM = 32'h08;
    localparam logic [31:0] P_DN_MM = 32'h04;

    function automatic logic [31:0] pulseVec();
        return 32'({bus.up_hh, bus.dn_hh, bus.up_mm, bus.dn_mm, bus.up_ss, bus.dn_ss});
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Order {mode, left, right, up, down}
    task automatic applyStimulus(input logic [4:0] btns);
        {bus.btn_mode, bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down} = btns;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [31:0] field, input logic [31:0] pulses);
        checkOutput({tag, ".field_sel"}, 32'(bus.field_sel), field);
        checkOutput({tag, ".set_mode"}, 32'(bus.set_mode), (field != 0) ? 32'd1 : 32'd0);
        checkOutput({tag, ".pulses"}, pulseVec(), pulses);
    endtask

    initial begin
        int blink_exp;
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;

        // Reset with every button held; nothing may fire once reset drops.
        applyStimulus(5'b11111);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkState("reset", 0, P_NONE);
        checkOutput("reset.blink", 32'(bus.blink), 1);
        repeat (3) tick();
        checkState("held_after_reset", 0, P_NONE);
        applyStimulus(5'b00000);
        tick();
        applyStimulus(5'b10000);
        tick();
        checkState("enter_set", 1, P_NONE);
        repeat (2) tick();
        checkState("mode_held", 1, P_NONE);
        applyStimulus(5'b00000);
        tick();

        // Three up taps in SET_HH.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'b00010);
            tick();
            checkState("tap_up_pulse", 1, P_UP_HH);
            applyStimulus(5'b00000);
            tick();
            checkOutput("tap_up_gap1", pulseVec(), P_NONE);
            tick();
            checkOutput("tap_up_gap2", pulseVec(), P_NONE);
        end

        // Move to SET_MM and hold down: pulses at 1, 9, 12, 15, 18, 21.
        applyStimulus(5'b00100);
        tick();
        checkState("right_to_mm", 2, P_NONE);
        applyStimulus(5'b00000);
        tick();
        applyStimulus(5'b00001);
        for (int k = 1; k <= 24; k++) begin
            tick();
            checkOutput($sformatf("hold_dn_c%0d", k), pulseVec(),
                        (k == 1 || k == 9 || k == 12 || k == 15 || k == 18 || k == 21) ? P_DN_MM : P_NONE);
            if (k == 21) applyStimulus(5'b00000);
        end

        // To SET_SS, then mode and right together leave set mode.
        applyStimulus(5'b00100);
        tick();
        checkState("right_to_ss", 3, P_NONE);
        applyStimulus(5'b00000);
        tick();
        applyStimulus(5'b10100);
        tick();
        checkState("mode_beats_right", 0, P_NONE);
        applyStimulus(5'b00000);
        tick();
        applyStimulus(5'b00010);
        tick();
        checkState("run_up_ignored", 0, P_NONE);
        tick();
        applyStimulus(5'b00001);
        tick();
        checkState("run_dn_ignored", 0, P_NONE);
        applyStimulus(5'b00000);
        tick();

        // Field change while up is held cancels repeat until a fresh press.
        applyStimulus(5'b10000);
        tick();
        checkState("reenter_set", 1, P_NONE);
        applyStimulus(5'b00000);
        tick();
        applyStimulus(5'b00010);
        tick();
        checkState("hold_up_first", 1, P_UP_HH);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("hold_up_wait", pulseVec(), P_NONE);
        end
        applyStimulus(5'b00110);
        tick();
        checkState("right_mid_hold", 2, P_NONE);
        applyStimulus(5'b00010);
        for (int k = 0; k < 15; k++) begin
            tick();
            checkState("repeat_cancelled", 2, P_NONE);
        end
        applyStimulus(5'b00000);
        tick();
        applyStimulus(5'b00010);
        tick();
        checkState("repress_up", 2, P_UP_MM);
        applyStimulus(5'b00000);
        tick();
        applyStimulus(5'b00011);
        for (int k = 0; k < 12; k++) begin
            tick();
            checkOutput("up_dn_both", pulseVec(), P_NONE);
        end
        applyStimulus(5'b00000);
        tick();

        // Idle in SET_SS until the timeout returns to RUN on cycle 40.
        applyStimulus(5'b00100);
        tick();
        checkState("timeout_start", 3, P_NONE);
        checkOutput("blink_c0", 32'(bus.blink), 1);
        applyStimulus(5'b00000);
        for (int k = 1; k <= 40; k++) begin
            tick();
`ifdef TIME_SET_CTRL_BLINK_EN
            blink_exp = (k == 40) ? 1 : (((k / 4) % 2 == 0) ? 1 : 0);
`else
            blink_exp = 1;
`endif
            checkOutput($sformatf("idle_c%0d.field_sel", k), 32'(bus.field_sel), (k == 40) ? 32'd0 : 32'd3);
            checkOutput($sformatf("idle_c%0d.blink", k), 32'(bus.blink), 32'(blink_exp));
        end
        checkOutput("timeout.set_mode", 32'(bus.set_mode), 0);

        // Reset in the middle of a hold; up held through reset must not pulse.
        applyStimulus(5'b10000);
        tick();
        applyStimulus(5'b00010);
        tick();
        checkState("pre_reset_pulse", 1, P_UP_HH);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checkState("reset_mid_hold", 0, P_NONE);
        applyStimulus(5'b10010);
        tick();
        checkState("enter_with_up_held", 1, P_NONE);
        repeat (10) tick();
        checkState("up_held_no_pulse", 1, P_NONE);
        applyStimulus(5'b00000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
